// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage.
// This stage owns the program counter and drives the combinational instruction
// memory. It captures each returned word into the IF/ID register, which decode
// takes with a valid/ready handshake.
// A redirect flushes IF/ID and moves the PC. A misaligned redirect, or a PC
// past the end of memory, parks the stage in HALT until the next reset.
module if_fetch_stage #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_BYTES = 1024,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic            halted,
    output logic [1:0]      fault_code,
    output logic [31:0]     fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
    localparam logic [1:0] FAULT_RANGE     = 2'b10;

    // Highest byte address at which a whole 32-bit word still fits in memory.
    localparam logic [XLEN-1:0] LAST_WORD_PC = XLEN'(IMEM_BYTES - 4);
    localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      fault_d;
    logic [XLEN-1:0] pc_q;

    logic            in_run;
    logic            oob;
    logic            redirect_misaligned;
    logic            redirect_ok;
    logic            xfer;
    logic            load_en;

    // Decode of the current cycle's events. The priority order is:
    // misaligned redirect, then aligned redirect, then out-of-range,
    // then a normal fetch or stall.
    assign in_run              = (state_q == RUN);
    assign oob                 = (pc_q > LAST_WORD_PC);
    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_ok         = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign xfer                = if_valid && id_ready;

    // A new word enters IF/ID only if the register is empty or is draining
    // this cycle. Any redirect turns the cycle into a bubble, and an
    // out-of-range PC blocks the load.
    assign load_en = in_run && (!if_valid || id_ready) && !redirect_valid && !oob;

    // The memory has no latency, so the PC register addresses it directly.
    assign imem_addr = pc_q;

    // State register for the RUN/HALT machine and its fault code.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fault_code <= FAULT_NONE;
        end else begin
            state_q    <= state_d;
            fault_code <= fault_d;
        end
    end

    // Next-state logic: faults are only raised while running. HALT exits only through reset.
    always_comb begin
        state_d = state_q;
        fault_d = fault_code;
        if (in_run) begin
            if (redirect_misaligned) begin
                state_d = HALT;
                fault_d = FAULT_MISALIGN;
            end else if (!redirect_valid && oob) begin
                state_d = HALT;
                fault_d = FAULT_RANGE;
            end
        end
    end

    // Output decode of the state machine.
    always_comb begin
        halted = (state_q == HALT);
    end

    // Program counter: an aligned redirect wins, otherwise advance on every load.
    // A misaligned redirect leaves the PC where it was, so the faulting context stays visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (in_run && redirect_ok) begin
            pc_q <= redirect_pc;
        end else if (load_en) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    // IF/ID valid flag. Any redirect in RUN flushes it, even if decode is
    // taking the word this cycle. Otherwise it is set by a load, or cleared
    // by a transfer that has no load behind it.
    // In HALT, nothing flushes the register, so a pending word drains normally.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
        end else if (in_run && redirect_valid) begin
            if_valid <= 1'b0;
        end else if (load_en) begin
            if_valid <= 1'b1;
        end else if (xfer) begin
            if_valid <= 1'b0;
        end
    end

    // IF/ID payload: updated only on a load, so it stays stable under back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_pc   <= '0;
            if_inst <= '0;
        end else if (load_en) begin
            if_pc   <= pc_q;
            if_inst <= imem_inst;
        end
    end

    // Count of instructions taken by decode. This includes transfers in redirect/fault cycles, and wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (xfer) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule
